// File: rtl/uart_pkg.sv
// Shared definitions for the host serial link: frame geometry, receive FSM
// state encoding and the default inter-byte timeout.
package uart_pkg;

   localparam int FRAME_MAX_BYTES     = 10;
   localparam int FRAME_W             = 8 * FRAME_MAX_BYTES;
   // 10 ms at 50 MHz
   localparam int DEFAULT_TIMEOUT_CYC = 500000;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DONE    = 2'd2
   } frame_state_e;

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte timer: counts enabled cycles since the last clear and flags
// expiry once LIMIT-1 is reached. The count saturates there, so expire_o
// stays high until the owner reacts or clears the timer.
module uart_byte_timer #(
   parameter int unsigned LIMIT = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] cnt_q;

   // Count up while enabled, hold at LAST, restart on clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && (cnt_q != LAST)) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_frame_rx.sv
// Receive-side frame assembler: gathers 1..MAX_BYTES bytes (first byte most
// significant) into a right-aligned word and pulses frame_valid. Partial
// frames are dropped on inter-byte timeout or rx_err (frame_err pulse) and
// silently when en_uart goes low.
//
// Handshake: rx_valid/rx_err are single-cycle strobes with no back-pressure;
// every strobe is consumed on the clock edge it is seen. frame_valid and
// frame_err are single-cycle pulses; frame_data is stable between
// frame_valid pulses.
module uart_frame_rx
   import uart_pkg::*;
#(
   parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
   parameter int MAX_BYTES   = FRAME_MAX_BYTES,
   localparam int W          = 8 * MAX_BYTES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_uart,
   input  logic         rx_valid,
   input  logic [7:0]   rx_data,
   input  logic         rx_err,
   input  logic [5:0]   DATARECVTIME,
   output logic [W-1:0] frame_data,
   output logic         frame_valid,
   output logic         frame_err,
   output logic         busy,
   output logic [3:0]   byte_cnt,
   output logic [1:0]   dbg_state
);

   localparam logic [5:0] MAX_LEN6 = 6'(MAX_BYTES);
   localparam logic [3:0] MAX_LEN4 = 4'(MAX_BYTES);

   frame_state_e state_q;
   logic [W-1:0] sh_q;
   logic [W-1:0] fdata_q;
   logic [3:0]   len_q;
   logic [3:0]   cnt_q;
   logic         fvalid_q;
   logic         ferr_q;

   logic [3:0]   len_req;
   logic         start_ok;
   logic         tmr_expire;
   logic [W-1:0] mask;

   // Requested length, clamped; only sampled when a frame starts
   assign len_req  = (DATARECVTIME > MAX_LEN6) ? MAX_LEN4 : DATARECVTIME[3:0];
   assign start_ok = en_uart && rx_valid && (len_req != 4'd0);

   uart_byte_timer #(
      .LIMIT (TIMEOUT_CYC)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    ((state_q != S_COLLECT) || rx_valid),
      .en_i     (state_q == S_COLLECT),
      .expire_o (tmr_expire)
   );

   // Keep only the low 8*len bits of the shift register on output
   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_BYTES; i++) begin
         if (i < int'(len_q)) mask[8*i +: 8] = 8'hFF;
      end
   end

   // Frame FSM with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         sh_q     <= '0;
         fdata_q  <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         fvalid_q <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         fvalid_q <= 1'b0;
         ferr_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_ok) begin
                  sh_q    <= {{(W-8){1'b0}}, rx_data};
                  cnt_q   <= 4'd1;
                  len_q   <= len_req;
                  state_q <= (len_req == 4'd1) ? S_DONE : S_COLLECT;
               end
            end
            S_COLLECT: begin
               if (!en_uart) begin
                  cnt_q   <= 4'd0;
                  state_q <= S_IDLE;
               end else if (rx_err) begin
                  ferr_q  <= 1'b1;
                  cnt_q   <= 4'd0;
                  state_q <= S_IDLE;
               end else if (rx_valid) begin
                  sh_q  <= {sh_q[W-9:0], rx_data};
                  cnt_q <= cnt_q + 4'd1;
                  if ((cnt_q + 4'd1) == len_q) state_q <= S_DONE;
               end else if (tmr_expire) begin
                  ferr_q  <= 1'b1;
                  cnt_q   <= 4'd0;
                  state_q <= S_IDLE;
               end
            end
            S_DONE: begin
               fdata_q  <= sh_q & mask;
               fvalid_q <= 1'b1;
               // A byte arriving here already opens the next frame
               if (start_ok) begin
                  sh_q    <= {{(W-8){1'b0}}, rx_data};
                  cnt_q   <= 4'd1;
                  len_q   <= len_req;
                  state_q <= (len_req == 4'd1) ? S_DONE : S_COLLECT;
               end else begin
                  cnt_q   <= 4'd0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               cnt_q   <= 4'd0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign frame_data  = fdata_q;
   assign frame_valid = fvalid_q;
   assign frame_err   = ferr_q;
   assign busy        = (state_q != S_IDLE);
   assign byte_cnt    = cnt_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: directed byte streams, expected frames/errors
// queued at stimulus time and checked by an independent output monitor.
module tb_uart_frame_rx;
   import uart_pkg::*;

   localparam int TO = 200;

   logic        clk;
   logic        rst_n;
   logic        en_uart;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_err;
   logic [5:0]  DATARECVTIME;
   logic [79:0] frame_data;
   logic        frame_valid;
   logic        frame_err;
   logic        busy;
   logic [3:0]  byte_cnt;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   // {is_err, frame_data expected at the pulse}
   logic [80:0] exp_q[$];
   logic [79:0] last_frame = '0;

   uart_frame_rx #(
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en_uart      (en_uart),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_err       (rx_err),
      .DATARECVTIME (DATARECVTIME),
      .frame_data   (frame_data),
      .frame_valid  (frame_valid),
      .frame_err    (frame_err),
      .busy         (busy),
      .byte_cnt     (byte_cnt),
      .dbg_state    (dbg_state)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required finish before time limit");
      $fatal(1);
   end

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   task automatic push_frame(input logic [79:0] d);
      exp_q.push_back({1'b0, d});
      last_frame = d;
   endtask

   task automatic push_err();
      exp_q.push_back({1'b1, last_frame});
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_byte_err(input logic [7:0] b);
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_err   = 1'b1;
      rx_data  = b;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      rx_err   = 1'b0;
   endtask

   task automatic pulse_err();
      @(posedge clk); #1;
      rx_err = 1'b1;
      @(posedge clk); #1;
      rx_err = 1'b0;
   endtask

   task automatic burst(input int n, input logic [7:0] first);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         rx_valid = 1'b1;
         rx_data  = first + 8'(i);
      end
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && (frame_valid || frame_err)) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_output: valid=%0b err=%0b data=%h, required no pulse",
                     frame_valid, frame_err, frame_data);
         end else begin
            logic [80:0] e;
            e = exp_q.pop_front();
            if ({frame_valid, frame_err, frame_data} === {~e[80], e[80], e[79:0]}) n_pass++;
            else $display("FAIL scoreboard: got valid=%0b err=%0b data=%h, required valid=%0b err=%0b data=%h",
                          frame_valid, frame_err, frame_data, ~e[80], e[80], e[79:0]);
         end
      end
   end

   // stimulus
   initial begin
      rst_n        = 1'b0;
      en_uart      = 1'b1;
      rx_valid     = 1'b0;
      rx_data      = 8'h00;
      rx_err       = 1'b0;
      DATARECVTIME = 6'd3;
      idle(3);
      @(negedge clk);
      check("reset_frame_data", frame_data, 80'h0);
      check("reset_valid", 80'(frame_valid), 80'h0);
      check("reset_err", 80'(frame_err), 80'h0);
      check("reset_busy", 80'(busy), 80'h0);
      check("reset_byte_cnt", 80'(byte_cnt), 80'h0);
      rst_n = 1'b1;

      // 1: len=3, bytes spaced 100 clk
      DATARECVTIME = 6'd3;
      push_frame(80'h112233);
      send_byte(8'h11);
      idle(98);
      send_byte(8'h22);
      idle(98);
      send_byte(8'h33);
      @(negedge clk);
      check("t1_done_busy", 80'(busy), 80'h1);
      check("t1_done_cnt", 80'(byte_cnt), 80'd3);
      idle(5);

      // timeout boundary: byte on the expiry cycle still wins
      DATARECVTIME = 6'd2;
      push_frame(80'h4455);
      send_byte(8'h44);
      idle(TO - 2);
      send_byte(8'h55);
      idle(5);

      // 2: len=10 back-to-back, next frame's first byte lands in DONE
      DATARECVTIME = 6'd10;
      push_frame(80'h0102030405060708090A);
      for (int i = 0; i <= 10; i++) begin
         @(posedge clk); #1;
         rx_valid = 1'b1;
         rx_data  = (i < 10) ? 8'(i + 1) : 8'hA1;
         if (i == 4) DATARECVTIME = 6'd2;
      end
      @(posedge clk); #1;
      rx_valid = 1'b0;
      @(negedge clk);
      check("t2_next_cnt", 80'(byte_cnt), 80'd1);
      check("t2_next_busy", 80'(busy), 80'h1);
      check("t2_next_state", 80'(dbg_state), 80'(S_COLLECT));
      push_frame(80'hA1B2);
      send_byte(8'hB2);
      idle(5);

      // 3: len=4, 2 bytes then silence -> timeout
      DATARECVTIME = 6'd4;
      send_byte(8'h66);
      send_byte(8'h77);
      push_err();
      idle(TO + 10);
      @(negedge clk);
      check("t3_busy", 80'(busy), 80'h0);
      check("t3_cnt", 80'(byte_cnt), 80'h0);
      check("t3_err_seen", 80'(exp_q.size()), 80'h0);
      push_frame(80'hC1C2C3C4);
      send_byte(8'hC1);
      send_byte(8'hC2);
      send_byte(8'hC3);
      send_byte(8'hC4);
      idle(5);

      // 4: rx_err on byte 2, rx_err alone mid-frame, rx_err in IDLE
      DATARECVTIME = 6'd2;
      send_byte(8'hD1);
      push_err();
      send_byte_err(8'hD2);
      idle(3);
      send_byte(8'hE1);
      push_err();
      pulse_err();
      idle(3);
      pulse_err();
      idle(3);
      @(negedge clk);
      check("t4_busy", 80'(busy), 80'h0);
      check("t4_drained", 80'(exp_q.size()), 80'h0);

      // 5: enable drop, len 0, len 15
      DATARECVTIME = 6'd3;
      send_byte(8'hF1);
      @(negedge clk);
      check("t5_cnt_before", 80'(byte_cnt), 80'd1);
      @(posedge clk); #1;
      en_uart = 1'b0;
      @(posedge clk); #1;
      en_uart = 1'b1;
      @(negedge clk);
      check("t5_en_busy", 80'(busy), 80'h0);
      check("t5_en_cnt", 80'(byte_cnt), 80'h0);
      DATARECVTIME = 6'd0;
      send_byte(8'h99);
      @(negedge clk);
      check("t5_len0_busy", 80'(busy), 80'h0);
      DATARECVTIME = 6'd15;
      push_frame(80'h10111213141516171819);
      burst(10, 8'h10);
      idle(5);

      // 6: async reset mid-frame
      DATARECVTIME = 6'd8;
      burst(5, 8'h20);
      @(negedge clk);
      check("t6_cnt_mid", 80'(byte_cnt), 80'd5);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_data", frame_data, 80'h0);
      check("t6_rst_valid", 80'(frame_valid), 80'h0);
      check("t6_rst_err", 80'(frame_err), 80'h0);
      check("t6_rst_busy", 80'(busy), 80'h0);
      check("t6_rst_cnt", 80'(byte_cnt), 80'h0);
      last_frame = '0;
      idle(2);
      @(negedge clk);
      rst_n = 1'b1;
      DATARECVTIME = 6'd3;
      push_frame(80'h313233);
      burst(3, 8'h31);
      idle(10);

      @(negedge clk);
      check("final_drain", 80'(exp_q.size()), 80'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
